// File: rtl/cg_vector_store_pkg.sv
// Shared definitions for the CG ping-pong vector store: element/lane geometry,
// the packed word type and the vector-length clamp.
// Optional build macro used by the store: CG_VSTORE_PREV_EN (second random read port).
package cg_pkg;

  localparam int ELEM_W = 32;
  localparam int NU     = 8;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int WORD_W = ELEM_W * NU;

  localparam logic [AW:0] WORDS_ONE   = (AW+1)'(1);
  localparam logic [AW:0] WORDS_DEPTH = (AW+1)'(DEPTH);

  typedef logic [WORD_W-1:0] word_t;

  // A zero-length vector would never complete, and anything past DEPTH would
  // run off the bank, so the programmed length is forced into 1..DEPTH.
  function automatic logic [AW:0] clamp_words(input logic [AW:0] tw);
    if (tw == '0)
      return WORDS_ONE;
    else if (tw > WORDS_DEPTH)
      return WORDS_DEPTH;
    else
      return tw;
  endfunction

endpackage

// File: rtl/cg_vstore_bank.sv
// One bank of the ping-pong store: DEPTH words, one write port, one registered
// read port that holds its output when not enabled.
// With CG_VSTORE_PREV_EN an extra always-enabled registered read port is added.
module cg_vstore_bank
  import cg_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
`ifdef CG_VSTORE_PREV_EN
  input  logic [AW-1:0]     paddr,
  output logic [WORD_W-1:0] pdata,
`endif
  output logic [WORD_W-1:0] rdata
);

  word_t mem [DEPTH];

  // Write port: contents are never cleared, only overwritten.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Main read port: output holds between reads.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

`ifdef CG_VSTORE_PREV_EN
  // Random-access read for the previous-vector path, every cycle.
  always_ff @(posedge clk) begin
    pdata <= mem[paddr];
  end
`endif

endmodule

// File: rtl/cg_vector_store.sv
// Ping-pong vector memory for one CG vector (r, p or x). The ALU writes the
// current iteration into the write bank while the previous iteration is
// replayed from the read bank; swap exchanges the roles.
// Optional build macro: CG_VSTORE_PREV_EN adds prev_addr/prev_data, a second
// registered random read of the read bank (out-of-range addresses return 0).
module cg_vector_store
  import cg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [AW:0]       total_words,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_rewind,
  input  logic              swap,
`ifdef CG_VSTORE_PREV_EN
  input  logic [AW-1:0]     prev_addr,
  output logic [WORD_W-1:0] prev_data,
`endif
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              rd_done,
  output logic              wr_full,
  output logic              ovf_err,
  output logic              swap_err
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic          bank_sel;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cfg_words;
  logic [AW:0]   last_idx;
  logic          wr_last;
  logic          rd_last;
  logic          wr_fire;
  logic          rd_fire;
  logic          rd_bank_p1;
  logic          rd_seen_p1;
  logic [WORD_W-1:0] q0;
  logic [WORD_W-1:0] q1;

  assign last_idx = cfg_words - WORDS_ONE;
  assign wr_last  = ({1'b0, wr_ptr} == last_idx);
  assign rd_last  = ({1'b0, rd_ptr} == last_idx);
  // swap takes priority: concurrent writes and reads are discarded.
  assign wr_fire  = wr_en && !wr_full && !swap;
  assign rd_fire  = rd_en && !swap;

`ifdef CG_VSTORE_PREV_EN
  logic [WORD_W-1:0] p0;
  logic [WORD_W-1:0] p1;
  logic              prev_bank_p1;
  logic              prev_oob_p1;
`endif

  cg_vstore_bank u_bank0 (
    .clk   (clk),
    .we    (wr_fire && !bank_sel),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_fire && bank_sel),
    .raddr (rd_ptr),
`ifdef CG_VSTORE_PREV_EN
    .paddr (prev_addr),
    .pdata (p0),
`endif
    .rdata (q0)
  );

  cg_vstore_bank u_bank1 (
    .clk   (clk),
    .we    (wr_fire && bank_sel),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_fire && !bank_sel),
    .raddr (rd_ptr),
`ifdef CG_VSTORE_PREV_EN
    .paddr (prev_addr),
    .pdata (p1),
`endif
    .rdata (q1)
  );

  // ---- stage p1: registered bank outputs ----
  // rd_data reads as 0 after reset until the first read lands.
  assign rd_data = rd_seen_p1 ? (rd_bank_p1 ? q1 : q0) : '0;

`ifdef CG_VSTORE_PREV_EN
  assign prev_data = prev_oob_p1 ? '0 : (prev_bank_p1 ? p1 : p0);

  // Track which bank and whether the address was in range for the prev read.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_bank_p1 <= 1'b0;
      prev_oob_p1  <= 1'b1;
    end else begin
      prev_bank_p1 <= ~bank_sel;
      prev_oob_p1  <= ({1'b0, prev_addr} >= cfg_words);
    end
  end
`endif

  // Pointers, bank selection, status pulses and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_sel   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cfg_words  <= clamp_words(total_words);
      wr_full    <= 1'b0;
      wr_done    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_done    <= 1'b0;
      ovf_err    <= 1'b0;
      swap_err   <= 1'b0;
      rd_bank_p1 <= 1'b0;
      rd_seen_p1 <= 1'b0;
    end else begin
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      if (swap) begin
        bank_sel  <= ~bank_sel;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        wr_full   <= 1'b0;
        cfg_words <= clamp_words(total_words);
        if (!wr_full) swap_err <= 1'b1;
      end else begin
        if (wr_en) begin
          if (wr_full) begin
            ovf_err <= 1'b1;
          end else if (wr_last) begin
            wr_ptr  <= '0;
            wr_full <= 1'b1;
            wr_done <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + PTR_ONE;
          end
        end
        // A rewind alongside a read lets the read use the old pointer first.
        if (rd_en) begin
          rd_valid   <= 1'b1;
          rd_done    <= rd_last;
          rd_bank_p1 <= ~bank_sel;
          rd_seen_p1 <= 1'b1;
          if (rd_rewind || rd_last) rd_ptr <= '0;
          else                      rd_ptr <= rd_ptr + PTR_ONE;
        end else if (rd_rewind) begin
          rd_ptr <= '0;
        end
      end
    end
  end

endmodule
